dll_rx_seq_checker_p: RTL
=========================

Name: dll_rx_seq_checker_p

Overview:
Parametrised next-generation Data Link Layer RX sequence checker. Sits between the RX DLLP/TLP demux and the Transaction Layer. Buffers incoming TLP beats per slot and holds each TLP until the LCRC verdict arrives. Then checks the sequence number against NEXT_RCV_SEQ using modulo arithmetic, schedules Ack/Nak, and forwards good TLPs with the sequence header stripped, under ready/valid backpressure.

Parameters:
DATA_W, 128, beat width in bits (multiple of 32, >=64)
SEQ_W, 12, sequence number width
LEN_W, 6, byte-length field width
DEPTH, 2, TLP slots in buffer (power of 2)
MAX_SEGS, 3, max beats per TLP

Ports:
clk  in  1  clock
rst  in  1  async active-low reset
in_vld  in  1  input beat valid
in_rdy  out  1  input beat accepted when in_vld&in_rdy
in_data  in  DATA_W  beat; first beat [DATA_W-1 -: 16] = seq header (low SEQ_W bits used)
in_len  in  LEN_W  bytes incl. 2B seq header, LCRC excluded; sampled on first beat
in_end  in  1  last beat of TLP
lcrc_done  in  1  verdict strobe for the TLP awaiting verdict
lcrc_ok  in  1  LCRC pass, qualified by lcrc_done
nrs  in  SEQ_W  NEXT_RCV_SEQ
nrs_inc  out  1  1-cycle pulse: increment NRS
ack_req  out  1  1-cycle pulse: schedule Ack
nak_req  out  1  1-cycle pulse: schedule Nak (first error only)
nak_sched  out  1  NAK_SCHEDULED flag
req_seq  out  SEQ_W  AckNak_Seq_Num for DLCSM, valid with ack_req/nak_req
out_vld  out  1  TL beat valid
out_rdy  in  1  TL ready
out_data  out  DATA_W  payload beat, seq stripped, MSB-aligned
out_len  out  LEN_W  in_len-2, valid on every out beat
out_end  out  1  last payload beat

Behaviour:
- Reset (rst=0, async): all outputs 0, buffer pointers/occupancy 0, FSMs to IDLE, nak_sched 0. in_rdy rises the first clk after deassertion.
- Write FSM: IDLE -> RECV (first accepted beat) -> RECV until in_end beat -> WAIT_VERDICT -> IDLE.
- in_rdy=0 in WAIT_VERDICT and when all DEPTH slots are committed. Writes go to an uncommitted slot.
- More than MAX_SEGS beats without in_end: TLP is marked oversize, extra beats are accepted and dropped, and the verdict is forced bad.
- Verdict, evaluated the cycle lcrc_done=1 in WAIT_VERDICT. lcrc_done outside WAIT_VERDICT is ignored. d=(rx_seq-nrs) mod 2^SEQ_W.
  - lcrc_ok=0 or oversize: Nak, slot discarded.
  - d==0: nrs_inc=1, ack_req=1, req_seq=rx_seq, nak_sched<=0, slot committed.
  - d>=2^(SEQ_W-1) (duplicate): ack_req=1, req_seq=nrs-1, slot discarded, nak_sched unchanged.
  - else (seq ahead, lost TLP): Nak, slot discarded.
- Nak path: req_seq=nrs-1 (mod 2^SEQ_W). nak_req pulses only if nak_sched was 0. nak_sched<=1.
- Read FSM: IDLE -> SEND (committed slot present) -> IDLE after the out_end beat is accepted, or SEND again if another slot is committed.
- Out beat k = {buf[k][DATA_W-17:0], buf[k+1][DATA_W-1 -: 16]}; missing bits are 0.
- Out beat count = ceil(out_len*8/DATA_W).
- out_* hold stable while out_vld&!out_rdy.
- Latency: commit at cycle T -> first out_vld at T+1 if the read side is idle.
- Slots are released when their out_end beat is accepted. Commit and release in the same cycle are both honoured.
- Slot pointers wrap modulo DEPTH. Order is preserved.
- Sequence compare wraps: nrs=4095, rx_seq=0 -> d=1 -> ahead.

Optional Feature:
SEQ_CHKR_STATS_EN
- Defined: adds outputs stat_good, stat_dup, stat_nak (16 bits each, saturating at 16'hFFFF), reset to 0, incremented on the respective verdict.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- nrs=5, 2-beat TLP seq=5, in_len=30, lcrc_ok -> nrs_inc, ack_req, req_seq=5; 2 out beats, out_len=28, out_end on beat 2.
- nrs=5, TLP seq=3, lcrc_ok -> ack_req, req_seq=4, no out_vld, no nrs_inc.
- nrs=5, TLP seq=7 then seq=8 -> nak_req once, req_seq=4, nak_sched=1; then seq=5 good -> nak_sched=0.
- lcrc_ok=0 with nrs=0 -> nak_req, req_seq=4095.
- DEPTH=2, out_rdy=0, three good TLPs -> in_rdy=0 after second commit; out_rdy=1 drains in order, third accepted.
- MAX_SEGS=3, 4-beat TLP with lcrc_ok -> nak_req, nothing forwarded; rst pulsed mid-RECV -> all outputs 0, next TLP processed normally.

Source files
------------

// File: rtl/dll_rx_seq_checker_p.sv
// DLL RX sequence checker: holds each TLP in a slot until its LCRC verdict, checks the sequence
// number against NEXT_RCV_SEQ, schedules Ack/Nak and forwards good TLPs. Optional: SEQ_CHKR_STATS_EN.
module dll_rx_seq_checker_p #(
   parameter int DATA_W   = 128,
   parameter int SEQ_W    = 12,
   parameter int LEN_W    = 6,
   parameter int DEPTH    = 2,
   parameter int MAX_SEGS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_end,
   input  logic              lcrc_done,
   input  logic              lcrc_ok,
   input  logic [SEQ_W-1:0]  nrs,
   output logic              nrs_inc,
   output logic              ack_req,
   output logic              nak_req,
   output logic              nak_sched,
   output logic [SEQ_W-1:0]  req_seq,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic [LEN_W-1:0]  out_len,
`ifdef SEQ_CHKR_STATS_EN
   output logic [15:0]       stat_good,
   output logic [15:0]       stat_dup,
   output logic [15:0]       stat_nak,
`endif
   output logic              out_end
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SEG_W = $clog2(MAX_SEGS + 1);
   localparam int HDR_W = 16;

   typedef enum logic [1:0] {W_IDLE, W_RECV, W_WAIT} wr_state_e;
   typedef enum logic {R_IDLE, R_SEND} rd_state_e;

   wr_state_e         wr_state_q, wr_state_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SEG_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [SEG_W-1:0]  out_idx_q, out_idx_d;
   logic              oversize_q, oversize_d;
   logic [SEQ_W-1:0]  rx_seq_q, rx_seq_d;
   logic              in_rdy_q, in_rdy_d;
   logic              nrs_inc_q, nrs_inc_d;
   logic              ack_req_q, ack_req_d;
   logic              nak_req_q, nak_req_d;
   logic              nak_sched_q, nak_sched_d;
   logic [SEQ_W-1:0]  req_seq_q, req_seq_d;

   logic [DATA_W-1:0] mem_q [DEPTH][MAX_SEGS];
   logic [LEN_W-1:0]  slot_len_q [DEPTH];
   logic [SEG_W-1:0]  slot_nbeats_q [DEPTH];

   logic              accept, mem_we, commit, rel;
   logic              is_good, is_dup, is_nak;
   logic [PTR_W-1:0]  wr_slot;
   logic [SEQ_W-1:0]  seq_diff, nrs_m1;
   logic [LEN_W-1:0]  out_len_w;
   int                nbeats_out;
   logic              out_last;
   logic [DATA_W-1:0] cur_beat;
   logic [HDR_W-1:0]  nxt_hdr;

   assign accept  = in_vld && in_rdy_q;
   // The slot being filled always sits just past the committed ones.
   assign wr_slot = PTR_W'((int'(rd_ptr_q) + int'(count_q)) % DEPTH);

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      wr_state_d  = wr_state_q;
      beat_cnt_d  = beat_cnt_q;
      oversize_d  = oversize_q;
      rx_seq_d    = rx_seq_q;
      nrs_inc_d   = 1'b0;
      ack_req_d   = 1'b0;
      nak_req_d   = 1'b0;
      nak_sched_d = nak_sched_q;
      req_seq_d   = req_seq_q;
      mem_we      = 1'b0;
      commit      = 1'b0;
      is_good     = 1'b0;
      is_dup      = 1'b0;
      is_nak      = 1'b0;
      seq_diff    = rx_seq_q - nrs;
      nrs_m1      = nrs - SEQ_W'(1);
      case (wr_state_q)
         W_IDLE, W_RECV: begin
            if (accept) begin
               if (wr_state_q == W_IDLE) rx_seq_d = in_data[DATA_W-HDR_W +: SEQ_W];
               if (beat_cnt_q < SEG_W'(MAX_SEGS)) begin
                  mem_we     = 1'b1;
                  beat_cnt_d = beat_cnt_q + SEG_W'(1);
               end else begin
                  oversize_d = 1'b1;
               end
               wr_state_d = in_end ? W_WAIT : W_RECV;
            end
         end
         W_WAIT: begin
            if (lcrc_done) begin
               // Top bit of the modulo difference set means the TLP is behind NRS.
               if (!lcrc_ok || oversize_q)    is_nak  = 1'b1;
               else if (seq_diff == '0)       is_good = 1'b1;
               else if (seq_diff[SEQ_W-1])    is_dup  = 1'b1;
               else                           is_nak  = 1'b1;
               if (is_good) begin
                  nrs_inc_d   = 1'b1;
                  ack_req_d   = 1'b1;
                  req_seq_d   = rx_seq_q;
                  nak_sched_d = 1'b0;
                  commit      = 1'b1;
               end
               if (is_dup) begin
                  ack_req_d = 1'b1;
                  req_seq_d = nrs_m1;
               end
               if (is_nak) begin
                  nak_req_d   = !nak_sched_q;
                  nak_sched_d = 1'b1;
                  req_seq_d   = nrs_m1;
               end
               wr_state_d = W_IDLE;
               beat_cnt_d = '0;
               oversize_d = 1'b0;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      out_len_w  = slot_len_q[rd_ptr_q] - LEN_W'(2);
      nbeats_out = (int'(out_len_w) * 8 + DATA_W - 1) / DATA_W;
      out_last   = (int'(out_idx_q) + 1 >= nbeats_out);
      cur_beat   = '0;
      nxt_hdr    = '0;
      if (int'(out_idx_q) < MAX_SEGS) cur_beat = mem_q[rd_ptr_q][out_idx_q];
      if (int'(out_idx_q) + 1 < int'(slot_nbeats_q[rd_ptr_q]))
         nxt_hdr = mem_q[rd_ptr_q][out_idx_q + SEG_W'(1)][DATA_W-1 -: HDR_W];
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      out_idx_d  = out_idx_q;
      rel        = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (count_q != '0 || commit) begin
               rd_state_d = R_SEND;
               out_idx_d  = '0;
            end
         end
         R_SEND: begin
            if (out_rdy) begin
               if (out_last) begin
                  rel       = 1'b1;
                  out_idx_d = '0;
                  rd_ptr_d  = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                  if (count_q == CNT_W'(1) && !commit) rd_state_d = R_IDLE;
               end else begin
                  out_idx_d = out_idx_q + SEG_W'(1);
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      count_d  = count_q + CNT_W'(commit) - CNT_W'(rel);
      in_rdy_d = (wr_state_d != W_WAIT) && (count_d < CNT_W'(DEPTH));
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_state_q  <= W_IDLE;
         rd_state_q  <= R_IDLE;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         beat_cnt_q  <= '0;
         out_idx_q   <= '0;
         oversize_q  <= 1'b0;
         rx_seq_q    <= '0;
         in_rdy_q    <= 1'b0;
         nrs_inc_q   <= 1'b0;
         ack_req_q   <= 1'b0;
         nak_req_q   <= 1'b0;
         nak_sched_q <= 1'b0;
         req_seq_q   <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         beat_cnt_q  <= beat_cnt_d;
         out_idx_q   <= out_idx_d;
         oversize_q  <= oversize_d;
         rx_seq_q    <= rx_seq_d;
         in_rdy_q    <= in_rdy_d;
         nrs_inc_q   <= nrs_inc_d;
         ack_req_q   <= ack_req_d;
         nak_req_q   <= nak_req_d;
         nak_sched_q <= nak_sched_d;
         req_seq_q   <= req_seq_d;
      end
   end

   // NOTE: slot storage is not reset; a slot is only read after it has been written and committed.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_slot][beat_cnt_q] <= in_data;
         slot_nbeats_q[wr_slot]     <= beat_cnt_q + SEG_W'(1);
      end
      if (accept && wr_state_q == W_IDLE) slot_len_q[wr_slot] <= in_len;
   end

   assign in_rdy    = in_rdy_q;
   assign nrs_inc   = nrs_inc_q;
   assign ack_req   = ack_req_q;
   assign nak_req   = nak_req_q;
   assign nak_sched = nak_sched_q;
   assign req_seq   = req_seq_q;
   assign out_vld   = (rd_state_q == R_SEND);
   assign out_data  = out_vld ? {cur_beat[DATA_W-HDR_W-1:0], nxt_hdr} : '0;
   assign out_len   = out_vld ? out_len_w : '0;
   assign out_end   = out_vld && out_last;

`ifdef SEQ_CHKR_STATS_EN
   logic [15:0] stat_good_q, stat_good_d;
   logic [15:0] stat_dup_q, stat_dup_d;
   logic [15:0] stat_nak_q, stat_nak_d;

   always_comb begin
      stat_good_d = stat_good_q;
      stat_dup_d  = stat_dup_q;
      stat_nak_d  = stat_nak_q;
      if (is_good && stat_good_q != 16'hFFFF) stat_good_d = stat_good_q + 16'd1;
      if (is_dup  && stat_dup_q  != 16'hFFFF) stat_dup_d  = stat_dup_q + 16'd1;
      if (is_nak  && stat_nak_q  != 16'hFFFF) stat_nak_d  = stat_nak_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_good_q <= '0;
         stat_dup_q  <= '0;
         stat_nak_q  <= '0;
      end else begin
         stat_good_q <= stat_good_d;
         stat_dup_q  <= stat_dup_d;
         stat_nak_q  <= stat_nak_d;
      end
   end

   assign stat_good = stat_good_q;
   assign stat_dup  = stat_dup_q;
   assign stat_nak  = stat_nak_q;
`endif

endmodule
